// File: rtl/star_trig_skew.sv
// Star trigger fan-out: takes one system trigger and produces N_CH delayed, width-shaped pulses.
// Each channel's delay and width come from a shadow register that is copied into the active counters when a shot starts.
module star_trig_skew #(
    parameter int N_CH  = 17,
    parameter int DLY_W = 16,
    parameter int WID_W = 8
) (
    input  logic              I_clk,
    input  logic              I_Rst,
    input  logic              I_Trig_in,
    input  logic              I_cfg_wren,
    input  logic [4:0]        I_cfg_addr,
    input  logic [31:0]       I_cfg_data,
    output logic [N_CH-1:0]   O_star,
    output logic              O_busy,
    output logic              O_cfg_err,
    output logic [15:0]       O_trig_cnt,
    output logic [15:0]       O_drop_cnt
);

    typedef enum logic {S_IDLE, S_RUN} state_t;
    typedef enum logic [1:0] {PH_WAIT, PH_PULSE, PH_DONE} phase_t;

    localparam logic [5:0] N_CH6 = 6'(N_CH);

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               t_d_q, t_d_d;
    logic               cfg_err_q, cfg_err_d;
    logic [15:0]        trig_cnt_q, trig_cnt_d;
    logic [15:0]        drop_cnt_q, drop_cnt_d;
    logic [N_CH-1:0]    star_q, star_d;
    logic [DLY_W-1:0]   shadow_dly_q [N_CH];
    logic [DLY_W-1:0]   shadow_dly_d [N_CH];
    logic [WID_W-1:0]   shadow_wid_q [N_CH];
    logic [WID_W-1:0]   shadow_wid_d [N_CH];
    logic [DLY_W-1:0]   dly_q [N_CH];
    logic [DLY_W-1:0]   dly_d [N_CH];
    logic [WID_W-1:0]   wid_q [N_CH];
    logic [WID_W-1:0]   wid_d [N_CH];
    phase_t             phase_q [N_CH];
    phase_t             phase_d [N_CH];

    logic               trig_edge;
    logic               addr_ok;
    logic               all_done;
    logic               cfg_data_unused;

    assign cfg_data_unused = ^I_cfg_data;

    always_comb begin
        t_d_d      = I_Trig_in;
        trig_edge  = I_Trig_in & ~t_d_q;
        addr_ok    = ({1'b0, I_cfg_addr} < N_CH6);
        cfg_err_d  = I_cfg_wren & ~addr_ok;
        state_d    = state_q;
        busy_d     = busy_q;
        trig_cnt_d = trig_cnt_q;
        drop_cnt_d = drop_cnt_q;
        star_d     = star_q;
        all_done   = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            shadow_dly_d[i] = shadow_dly_q[i];
            shadow_wid_d[i] = shadow_wid_q[i];
            dly_d[i]        = dly_q[i];
            wid_d[i]        = wid_q[i];
            phase_d[i]      = phase_q[i];
            if (I_cfg_wren && addr_ok && (I_cfg_addr == 5'(i))) begin
                shadow_dly_d[i] = I_cfg_data[DLY_W-1:0];
                shadow_wid_d[i] = I_cfg_data[16+WID_W-1:16];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (trig_edge) begin
                    // The load cycle also counts as the first WAIT step, so delay 0 pulses on the very next output.
                    for (int i = 0; i < N_CH; i++) begin
                        wid_d[i] = shadow_wid_q[i];
                        if (shadow_wid_q[i] == '0) begin
                            phase_d[i] = PH_DONE;
                            star_d[i]  = 1'b0;
                        end else if (shadow_dly_q[i] == '0) begin
                            phase_d[i] = PH_PULSE;
                            star_d[i]  = 1'b1;
                        end else begin
                            phase_d[i] = PH_WAIT;
                            dly_d[i]   = shadow_dly_q[i] - DLY_W'(1);
                            star_d[i]  = 1'b0;
                        end
                    end
                    if (trig_cnt_q != 16'hFFFF) trig_cnt_d = trig_cnt_q + 16'd1;
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                if (trig_edge && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
                for (int i = 0; i < N_CH; i++) begin
                    case (phase_q[i])
                        PH_WAIT: begin
                            if (dly_q[i] == '0) begin
                                phase_d[i] = PH_PULSE;
                                star_d[i]  = 1'b1;
                            end else begin
                                dly_d[i] = dly_q[i] - DLY_W'(1);
                            end
                        end
                        PH_PULSE: begin
                            if (wid_q[i] == WID_W'(1)) begin
                                phase_d[i] = PH_DONE;
                                star_d[i]  = 1'b0;
                            end else begin
                                wid_d[i] = wid_q[i] - WID_W'(1);
                            end
                        end
                        default: star_d[i] = 1'b0;
                    endcase
                    if (phase_d[i] != PH_DONE) all_done = 1'b0;
                end
                // Busy drops on the same edge the last pulse ends, so an edge on the next clock re-arms.
                if (all_done) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge I_clk or posedge I_Rst) begin
        if (I_Rst) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            t_d_q      <= 1'b0;
            cfg_err_q  <= 1'b0;
            trig_cnt_q <= '0;
            drop_cnt_q <= '0;
            star_q     <= '0;
            for (int i = 0; i < N_CH; i++) begin
                shadow_dly_q[i] <= '0;
                shadow_wid_q[i] <= '0;
                dly_q[i]        <= '0;
                wid_q[i]        <= '0;
                phase_q[i]      <= PH_DONE;
            end
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            t_d_q        <= t_d_d;
            cfg_err_q    <= cfg_err_d;
            trig_cnt_q   <= trig_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            star_q       <= star_d;
            shadow_dly_q <= shadow_dly_d;
            shadow_wid_q <= shadow_wid_d;
            dly_q        <= dly_d;
            wid_q        <= wid_d;
            phase_q      <= phase_d;
        end
    end

    assign O_star     = star_q;
    assign O_busy     = busy_q;
    assign O_cfg_err  = cfg_err_q;
    assign O_trig_cnt = trig_cnt_q;
    assign O_drop_cnt = drop_cnt_q;

endmodule

// File: doc/star_trig_skew.md
# star_trig_skew

Per-slot trigger skew and pulse shaper that sits directly downstream of the trigger generator. It takes the single system trigger and drives the 17 star trigger lines toward the output buffers. Each channel has its own programmable delay and pulse width, so the trigger arrives deskewed and correctly shaped at every slot. Configuration arrives over a simple register-write port from the control path in the same clock domain.

## Interface

- N_CH, 17, number of star trigger channels (1..32)
- DLY_W, 16, delay counter width in cycles
- WID_W, 8, pulse width counter width in cycles
- I_clk  in  1  system clock; all logic on rising edge
- I_Rst  in  1  asynchronous, active-high reset
- I_Trig_in  in  1  synchronous trigger level; rising edge starts a shot
- I_cfg_wren  in  1  one-cycle config write strobe
- I_cfg_addr  in  5  channel index
- I_cfg_data  in  32  [DLY_W-1:0] = delay, [16+WID_W-1:16] = width; other bits ignored
- O_star  out  N_CH  shaped trigger per channel, registered
- O_busy  out  1  shot in progress
- O_cfg_err  out  1  one-cycle pulse on a write to addr >= N_CH
- O_trig_cnt  out  16  accepted triggers, saturating
- O_drop_cnt  out  16  triggers dropped while busy, saturating

## Operation

- Edge detect: register t_d <= I_Trig_in. edge = I_Trig_in & ~t_d.
- Shadow regs: one delay/width pair per channel. Written on I_cfg_wren when I_cfg_addr < N_CH.
  - Writes are accepted in any state. The active shot never changes.
  - Addr >= N_CH: no register change. O_cfg_err = 1 on the next cycle.
- Active regs: per-channel dly_cnt, wid_cnt and phase {WAIT, PULSE, DONE}.
- FSM IDLE:
  - On edge, copy shadow to active for all channels.
  - Width 0 gives phase DONE (channel disabled). Otherwise phase WAIT, dly_cnt = delay, wid_cnt = width.
  - trig_cnt++ (saturate at 0xFFFF). Go to RUN.
- FSM RUN, per channel each cycle:
  - WAIT with dly_cnt = 0 enters PULSE (O_star = 1). Otherwise dly_cnt decrements.
  - PULSE: wid_cnt decrements. When wid_cnt reaches 1 the next state is DONE, with O_star = 0 on the following cycle.
  - RUN goes to IDLE in the cycle after all channels are DONE with O_star all zero.
- Edge while in RUN: dropped, drop_cnt++ (saturate). No effect on outputs.
- A config write in the same cycle as an accepted edge does not affect that shot. The shot uses the pre-write shadow value.
- Reset mid-shot: all O_star drop to 0 immediately (async). FSM goes to IDLE, shadows and counters clear, t_d = 0.

## Timing

- Reset values: O_star = 0, O_busy = 0, O_cfg_err = 0, O_trig_cnt = 0, O_drop_cnt = 0. All shadow delay and width = 0, so every channel is disabled after reset.
- Edge sampled at clock k:
  - O_busy = 1 from k+1.
  - Channel with delay D, width W ≥ 1: O_star high for clocks k+1+D through k+D+W (exactly W cycles).
  - O_busy falls at clock max over enabled channels of (k+1+D+W). O_star for every channel is already 0 at that clock.
- All channels disabled: O_busy high for exactly one cycle (k+1).
- Earliest re-arm: an edge at the same clock where O_busy falls is accepted.
- Config write at clock k: the shadow register is updated at k+1. O_cfg_err (for a bad address) is high at k+1 only.
- Steady-high I_Trig_in produces no further edges. A new shot requires a low cycle first.
- Max shot length is (2^DLY_W − 1) + (2^WID_W − 1) + 1 cycles.

## Test plan

- Reset, then edge at k with no config: O_busy high only at k+1, O_star stays 0, O_trig_cnt = 1.
- ch0 delay 0 width 1; ch16 delay 10 width 4; edge at k:
  - O_star[0] high at k+1 only.
  - O_star[16] high k+11..k+14.
  - O_busy falls at k+15.
- ch3 delay 5 width 3; three edges spaced 4 cycles apart: first accepted, next two dropped (O_trig_cnt = 1, O_drop_cnt = 2). An edge exactly when O_busy falls is accepted (O_trig_cnt = 2).
- Write ch2 width 8 in the same cycle as the edge, with old width 2: this shot is 2 cycles wide and the next shot is 8 cycles wide.
- Write to addr 17 and addr 31: O_cfg_err pulses one cycle each, and no channel's timing changes on the next shot.
- Assert I_Rst mid-pulse on ch5 (delay 0, width 200): O_star goes 0 asynchronously, O_busy = 0, counters = 0. After release an edge produces no pulse, because the shadows were cleared.
